// File: rtl/add_sub_serial_pkg.sv
// Shared definitions for the digit-serial adder.
//   state_t   : FSM encoding (IDLE, RUN, DONE)
//   SLICE_W   : bits handled per clock by the lookahead slice
//   cnt_width : slice-counter width for a given slice count (minimum 1 bit)
package add_sub_serial_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int nslice);
    if (nslice <= 1) return 1;
    return $clog2(nslice);
  endfunction

endpackage

// File: rtl/add_sub_cla_add_4bit.sv
// Combinational 4-bit carry-lookahead adder slice, the addition twin of the
// borrow-lookahead subtract slice.
//   A, B : 4-bit addends
//   Cin  : carry into bit 0
//   SUM  : A + B + Cin, low 4 bits
//   Cout : carry out of bit 3
module add_sub_cla_add_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] SUM,
  output logic       Cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Carries are flattened to two-level logic so no carry ripples through
  // the slice; p uses OR, which is safe because g already covers a&b.
  always_comb begin
    g    = A & B;
    p    = A | B;
    c[0] = Cin;
    c[1] = g[0] | (p[0] & Cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & Cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & Cin);
    SUM  = A ^ B ^ c[3:0];
    Cout = c[4];
  end

endmodule

// File: rtl/add_sub_serial_add.sv
// Digit-serial adder: computes A + B + Cin on WIDTH-bit operands, one 4-bit
// lookahead slice per clock, least-significant slice first.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_valid/o_ready         : operand handshake (i_a, i_b, i_cin)
//   o_valid/i_ready         : result handshake (o_sum, o_cout)
// WIDTH must be a multiple of 4.
module add_sub_serial_add
  import add_sub_serial_pkg::*;
#(
  parameter int WIDTH = 28
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = cnt_width(NSLICE);
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       slice_sum;
  logic             slice_cout;

  add_sub_cla_add_4bit u_slice (
    .A    (a_sh[3:0]),
    .B    (b_sh[3:0]),
    .Cin  (carry),
    .SUM  (slice_sum),
    .Cout (slice_cout)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid)            state_nxt = RUN;
      RUN:     if (cnt == LAST_SLICE)  state_nxt = DONE;
      DONE:    if (i_ready)            state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // Handshake flags decode the registered state only, so neither i_valid
  // nor i_ready reaches an output combinationally.
  always_comb begin
    o_ready = (state == IDLE);
    o_valid = (state == DONE);
    o_sum   = sum_sh;
    o_cout  = carry;
  end

  // Operands shift right so the active slice always sits in bits [3:0];
  // each new sum slice enters at the top and drifts down to its place
  // after NSLICE shifts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_sh  <= i_a;
            b_sh  <= i_b;
            carry <= i_cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> SLICE_W;
          b_sh   <= b_sh >> SLICE_W;
          sum_sh <= (sum_sh >> SLICE_W) | (WIDTH'(slice_sum) << (WIDTH - SLICE_W));
          carry  <= slice_cout;
          cnt    <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_sub_serial_add.sv
// Directed and randomized bench for the digit-serial adder (WIDTH = 28).
module tb_add_sub_serial_add;

  localparam int WIDTH = 28;

  logic             i_clk   = 1'b0;
  logic             i_rst_n = 1'b1;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [WIDTH-1:0] i_a     = '0;
  logic [WIDTH-1:0] i_b     = '0;
  logic             i_cin   = 1'b0;
  logic             o_valid;
  logic             i_ready = 1'b0;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  add_sub_serial_add #(.WIDTH(WIDTH)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_cin   (i_cin),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sum   (o_sum),
    .o_cout  (o_cout)
  );

  // Present one operand set and let it be accepted; a bounded wait for
  // o_ready that expires is recorded as a failed comparison.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin);
    int n = 0;
    while (o_ready !== 1'b1 && n < 40) begin
      @(posedge i_clk); #1; n++;
    end
    if (o_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL start_op: o_ready=%b required 1 within 40 cycles", o_ready);
    end
    i_valid = 1'b1; i_a = a; i_b = b; i_cin = cin;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_a = 28'h5A5A5A5; i_b = 28'hA5A5A5A; i_cin = 1'b1;
  endtask

  // Counts edges after the accepting edge until o_valid, bounded at 40.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (o_valid !== 1'b1 && lat < 40) begin
      @(posedge i_clk); #1; lat++;
    end
  endtask

  task automatic consume();
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3 i_rst_n = 1'b0;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    checks++; if (o_sum !== 28'h0) begin errors++; $display("FAIL reset_sum: got %h want 0000000", o_sum); end
    checks++; if (o_cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", o_cout); end
    @(negedge i_clk); @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle: ready=%b valid=%b want 1/0", o_ready, o_valid);
    end
  endtask

  task automatic test_basic();
    i_ready = 1'b1;
    start_op(28'h0000001, 28'h0000001, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      @(posedge i_clk); #1;
      checks++;
      if (o_valid !== (k == 7)) begin
        errors++; $display("FAIL basic_valid_edge%0d: got %b want %b", k, o_valid, (k == 7));
      end
    end
    checks++; if (o_sum !== 28'h0000002) begin errors++; $display("FAIL basic_sum: got %h want 0000002", o_sum); end
    checks++; if (o_cout !== 1'b0) begin errors++; $display("FAIL basic_cout: got %b want 0", o_cout); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_done: got %b want 0", o_ready); end
    @(posedge i_clk); #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b want 0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back: got %b want 1", o_ready); end
    i_ready = 1'b0;
  endtask

  task automatic test_full_ripple();
    logic [WIDTH-1:0] va [2] = '{28'hFFFFFFF, 28'hFFFFFFF};
    logic [WIDTH-1:0] vb [2] = '{28'h0000000, 28'hFFFFFFF};
    logic [WIDTH-1:0] vs [2] = '{28'h0000000, 28'hFFFFFFF};
    int lat;
    for (int i = 0; i < 2; i++) begin
      start_op(va[i], vb[i], 1'b1);
      wait_valid(lat);
      checks++; if (lat != 7) begin errors++; $display("FAIL ripple%0d_latency: got %0d want 7", i, lat); end
      checks++; if (o_sum !== vs[i]) begin errors++; $display("FAIL ripple%0d_sum: got %h want %h", i, o_sum, vs[i]); end
      checks++; if (o_cout !== 1'b1) begin errors++; $display("FAIL ripple%0d_cout: got %b want 1", i, o_cout); end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    i_ready = 1'b0;
    start_op(28'h1234567, 28'h0FEDCBA, 1'b0);
    wait_valid(lat);
    checks++; if (lat != 7) begin errors++; $display("FAIL bp_latency: got %0d want 7", lat); end
    i_valid = 1'b1; i_a = 28'h0000005; i_b = 28'h0000000; i_cin = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_sum !== 28'h2222221 || o_cout !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b ready=%b sum=%h cout=%b want 1/0/2222221/0",
                 k, o_valid, o_ready, o_sum, o_cout);
      end
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    consume();
    checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: valid=%b ready=%b want 0/1", o_valid, o_ready);
    end
    @(posedge i_clk); #1;
    checks++; if (o_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ignored_req: ready=%b want 1", o_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bit saw_valid = 1'b0;
    i_ready = 1'b1;
    start_op(28'h1234567, 28'h0FEDCBA, 1'b0);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    #3 i_rst_n = 1'b0;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", o_ready); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", o_valid); end
    checks++; if (o_sum !== 28'h0) begin errors++; $display("FAIL midrst_sum: got %h want 0000000", o_sum); end
    checks++; if (o_cout !== 1'b0) begin errors++; $display("FAIL midrst_cout: got %b want 0", o_cout); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge i_clk); #1;
      if (o_valid !== 1'b0) saw_valid = 1'b1;
    end
    checks++; if (saw_valid) begin errors++; $display("FAIL midrst_no_valid: got 1 want 0"); end
    start_op(28'h1234567, 28'h0FEDCBA, 1'b1);
    wait_valid(lat);
    checks++; if (lat != 7) begin errors++; $display("FAIL midrst_after_latency: got %0d want 7", lat); end
    checks++; if (o_sum !== 28'h2222222) begin errors++; $display("FAIL midrst_after_sum: got %h want 2222222", o_sum); end
    checks++; if (o_cout !== 1'b0) begin errors++; $display("FAIL midrst_after_cout: got %b want 0", o_cout); end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic [WIDTH:0]   exp;
    int               lat;
    int               stall;
    for (int n = 0; n < 1000; n++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      c = 1'($urandom_range(0, 1));
      exp = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(c);
      i_ready = 1'($urandom_range(0, 1));
      start_op(a, b, c);
      wait_valid(lat);
      checks++;
      if (lat != 7 || {o_cout, o_sum} !== exp) begin
        errors++;
        $display("FAIL b2b_op%0d: a=%h b=%h cin=%b lat=%0d got %b_%h want 7 %b_%h",
                 n, a, b, c, lat, o_cout, o_sum, exp[WIDTH], exp[WIDTH-1:0]);
      end
      if (i_ready == 1'b0) begin
        stall = $urandom_range(0, 3);
        for (int s = 0; s < stall; s++) begin
          @(posedge i_clk); #1;
        end
        if (stall > 0) begin
          checks++;
          if (o_valid !== 1'b1 || {o_cout, o_sum} !== exp) begin
            errors++;
            $display("FAIL b2b_stall%0d: valid=%b got %b_%h want 1 %b_%h",
                     n, o_valid, o_cout, o_sum, exp[WIDTH], exp[WIDTH-1:0]);
          end
        end
      end
      consume();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_full_ripple();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
